lc3_timer_ctrl: RTL and testbench

//  Memory-mapped controller for a 24-bit prescaled down-counter timer on the LC-3 I/O bus.

---
 rtl/lc3_timer_ctrl.sv | 154 +++++++++++++++
 tb/tb_lc3_timer_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_timer_ctrl.sv
// LC-3 memory-mapped timer: config registers, prescaler, start/stop/one-shot
// sequencing and a 24-bit down-counter with level interrupt on expiry.
module lc3_timer_ctrl #(
  parameter int unsigned CNT_W = 24,
  parameter int unsigned PRE_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sel,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        rvalid,
  output logic        irq,
  input  logic        irq_ack,
  output logic        tc,
  output logic        tp
);

  localparam int unsigned HI_W = CNT_W - 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic             oneshot;
  logic             ie;
  logic [PRE_W-1:0] prescale;
  logic [PRE_W-1:0] pre_cnt;
  logic [CNT_W-1:0] reload;
  logic [CNT_W-1:0] reload_m1;
  logic [CNT_W-1:0] count;
  logic [HI_W-1:0]  shadow;
  logic             expired;

  logic        rd, wr;
  logic        ctrl_wr, stop_req, start_req, w1c;
  logic        tick, expire;
  logic [15:0] rd_val;

  assign rd        = sel & ~we;
  assign wr        = sel & we;
  assign ctrl_wr   = wr && (addr == 3'd0);
  assign stop_req  = ctrl_wr & ~wdata[0];
  assign start_req = ctrl_wr & wdata[0];
  assign w1c       = wr && (addr == 3'd5) && wdata[0];

  // RELOAD=0 wraps to all-ones, giving a full 2^CNT_W period.
  assign reload_m1 = reload - CNT_W'(1);

  assign tick   = (state == RUN) && (pre_cnt == '0);
  // A stop write in the expiry cycle suppresses the expiry entirely.
  assign expire = tick && (count == '0) && !stop_req;

  assign irq = expired & ie;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_req) state_nxt = RUN;
      RUN:  if (stop_req || (expire && oneshot)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    unique case (addr)
      3'd0: begin
        rd_val[0]          = (state == RUN);
        rd_val[1]          = oneshot;
        rd_val[2]          = ie;
        rd_val[8 +: PRE_W] = prescale;
      end
      3'd1:    rd_val            = reload[15:0];
      3'd2:    rd_val[HI_W-1:0]  = reload[CNT_W-1:16];
      3'd3:    rd_val            = count[15:0];
      3'd4:    rd_val[HI_W-1:0]  = shadow;
      3'd5:    rd_val[1:0]       = {(state == RUN), expired};
      default: rd_val            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oneshot  <= 1'b0;
      ie       <= 1'b0;
      prescale <= '0;
      reload   <= '0;
    end else begin
      if (ctrl_wr) begin
        oneshot  <= wdata[1];
        ie       <= wdata[2];
        prescale <= wdata[8 +: PRE_W];
      end
      if (wr && (addr == 3'd1)) reload[15:0]       <= wdata;
      if (wr && (addr == 3'd2)) reload[CNT_W-1:16] <= wdata[HI_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      pre_cnt <= '0;
    end else if ((state == IDLE) && start_req) begin
      count   <= reload_m1;
      pre_cnt <= wdata[8 +: PRE_W];
    end else if ((state == RUN) && !stop_req) begin
      if (tick) begin
        pre_cnt <= prescale;
        if (count != '0)  count <= count - CNT_W'(1);
        else if (!oneshot) count <= reload_m1;
      end else begin
        pre_cnt <= pre_cnt - PRE_W'(1);
      end
    end
  end

  // Set has priority over both clear sources.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      expired <= 1'b0;
      tc      <= 1'b0;
      tp      <= 1'b0;
    end else begin
      if (irq_ack || w1c) expired <= 1'b0;
      if (expire)         expired <= 1'b1;
      tc <= expire;
      if (expire) tp <= ~tp;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      shadow <= '0;
    end else begin
      rvalid <= rd;
      if (rd) rdata <= rd_val;
      if (rd && (addr == 3'd3)) shadow <= count[CNT_W-1:16];
    end
  end

endmodule

// File: tb/tb_lc3_timer_ctrl.sv
// Self-checking bench for lc3_timer_ctrl: directed scenarios plus randomized
// bus traffic compared cycle-by-cycle against a behavioural model.
module tb_lc3_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sel, we, irq_ack;
  logic [2:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rvalid, irq, tc, tp;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_n    = 0;

  bit          m_run, m_os, m_ie, m_exp, m_tc, m_tp, m_rvalid;
  logic [7:0]  m_pre_cfg, m_pre, m_shadow;
  logic [23:0] m_reload, m_count;
  logic [15:0] m_rdata;

  lc3_timer_ctrl #(.CNT_W(24), .PRE_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .irq     (irq),
    .irq_ack (irq_ack),
    .tc      (tc),
    .tp      (tp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_run = 0; m_os = 0; m_ie = 0; m_exp = 0; m_tc = 0; m_tp = 0; m_rvalid = 0;
    m_pre_cfg = '0; m_pre = '0; m_shadow = '0; m_reload = '0; m_count = '0; m_rdata = '0;
  endtask

  // One clock edge of the timer as the register map and timing rules describe it.
  task automatic model_step();
    bit rdq, wrq, cw, stop, start, tick, ex, n_run, old_os;
    logic [15:0] rv;
    logic [23:0] rl_m1, old_cnt;
    logic [7:0]  old_pcfg;
    if (!reset_n) begin
      model_reset();
      return;
    end
    rdq   = sel && !we;
    wrq   = sel && we;
    cw    = wrq && (addr == 3'd0);
    stop  = cw && !wdata[0];
    start = cw && wdata[0];
    case (addr)
      3'd0:    rv = {m_pre_cfg, 5'b0, m_ie, m_os, m_run};
      3'd1:    rv = m_reload[15:0];
      3'd2:    rv = {8'h00, m_reload[23:16]};
      3'd3:    rv = m_count[15:0];
      3'd4:    rv = {8'h00, m_shadow};
      3'd5:    rv = {14'b0, m_run, m_exp};
      default: rv = 16'h0000;
    endcase
    rl_m1    = m_reload - 24'd1;
    old_cnt  = m_count;
    old_pcfg = m_pre_cfg;
    old_os   = m_os;
    tick     = m_run && (m_pre == 8'd0);
    ex       = tick && (old_cnt == 24'd0) && !stop;
    n_run    = m_run;
    if (m_run) begin
      if (stop) n_run = 0;
      else begin
        if (ex && old_os) n_run = 0;
        if (tick) begin
          m_pre = old_pcfg;
          if (old_cnt != 24'd0) m_count = old_cnt - 24'd1;
          else if (!old_os)     m_count = rl_m1;
        end else begin
          m_pre = m_pre - 8'd1;
        end
      end
    end else if (start) begin
      n_run   = 1;
      m_count = rl_m1;
      m_pre   = wdata[15:8];
    end
    m_run = n_run;
    if (cw) begin
      m_os      = wdata[1];
      m_ie      = wdata[2];
      m_pre_cfg = wdata[15:8];
    end
    if (wrq && addr == 3'd1) m_reload[15:0]  = wdata;
    if (wrq && addr == 3'd2) m_reload[23:16] = wdata[7:0];
    if (irq_ack || (wrq && addr == 3'd5 && wdata[0])) m_exp = 0;
    if (ex) m_exp = 1;
    m_tc = ex;
    if (ex) m_tp = !m_tp;
    if (rdq && addr == 3'd3) m_shadow = old_cnt[23:16];
    m_rvalid = rdq;
    if (rdq) m_rdata = rv;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    cyc_n++;
    #1;
    check("flags{tc,tp,irq,rvalid}", 32'({tc, tp, irq, rvalid}),
          32'({m_tc, m_tp, m_exp & m_ie, m_rvalid}));
    if (m_rvalid) check("rdata", 32'(rdata), 32'(m_rdata));
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
    sel = 1; we = 1; addr = a; wdata = d;
    cyc();
    sel = 0; we = 0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [15:0] d);
    sel = 1; we = 0; addr = a;
    cyc();
    sel = 0;
    d = rdata;
  endtask

  task automatic wait_tc(input int max, output int t);
    t = -1000;
    for (int i = 0; i < max; i++) begin
      cyc();
      if (tc) begin
        t = cyc_n;
        break;
      end
    end
  endtask

  task automatic rand_inputs();
    int unsigned r;
    r       = $urandom_range(0, 99);
    sel     = 0;
    we      = 0;
    addr    = 3'($urandom_range(0, 7));
    wdata   = 16'($urandom);
    irq_ack = ($urandom_range(0, 9) == 0);
    if (r >= 35 && r < 65) begin
      sel = 1;
    end else if (r >= 65) begin
      sel = 1;
      we  = 1;
      case (addr)
        3'd0: wdata = 16'($urandom_range(0, 3) << 8) | 16'($urandom_range(0, 7) & 6)
                      | 16'($urandom_range(0, 3) != 0);
        3'd1: wdata = 16'($urandom_range(0, 9));
        3'd2: wdata = ($urandom_range(0, 9) == 0) ? 16'h0001 : 16'h0000;
        default: ;
      endcase
    end
  endtask

  initial begin
    logic [15:0] d;
    int t0, t1, t2;
    bit seen;

    reset_n = 0; sel = 0; we = 0; addr = '0; wdata = '0; irq_ack = 0;
    model_reset();
    repeat (3) cyc();
    reset_n = 1;
    cyc();

    // Periodic: RELOAD=5, PRESCALE=0
    bus_wr(3'd1, 16'd5);
    bus_wr(3'd2, 16'd0);
    bus_wr(3'd0, 16'h0001);
    t0 = cyc_n;
    wait_tc(20, t1);
    check("periodic first tc delay", 32'(t1 - t0), 32'd5);
    wait_tc(20, t2);
    check("periodic tc period", 32'(t2 - t1), 32'd5);
    bus_wr(3'd0, 16'h0000);

    // Prescale + one-shot: RELOAD=3, PRESCALE=3
    bus_wr(3'd1, 16'd3);
    bus_wr(3'd0, 16'h0303);
    t0 = cyc_n;
    wait_tc(40, t1);
    check("oneshot tc delay", 32'(t1 - t0), 32'd12);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      seen |= tc;
    end
    check("oneshot no second tc", 32'(seen), 32'd0);
    bus_rd(3'd0, d);
    check("oneshot CTRL.EN", 32'(d[0]), 32'd0);
    bus_rd(3'd5, d);
    check("oneshot STATUS", 32'(d[1:0]), 32'd1);
    bus_rd(3'd3, d);
    check("oneshot COUNT_LO", 32'(d), 32'd0);

    // IRQ handshake and set-wins-over-ack
    bus_wr(3'd5, 16'h0001);
    bus_wr(3'd1, 16'd5);
    bus_wr(3'd0, 16'h0005);
    wait_tc(20, t1);
    check("irq on expiry", 32'(irq), 32'd1);
    irq_ack = 1;
    cyc();
    irq_ack = 0;
    check("irq after ack", 32'(irq), 32'd0);
    while (cyc_n < t1 + 4) cyc();
    irq_ack = 1;
    cyc();
    irq_ack = 0;
    check("tc on ack cycle", 32'(tc), 32'd1);
    check("irq ack vs expiry", 32'(irq), 32'd1);
    bus_wr(3'd0, 16'h0001);
    check("irq after IE cleared", 32'(irq), 32'd0);
    bus_rd(3'd5, d);
    check("EXPIRED kept with IE=0", 32'(d[0]), 32'd1);
    bus_wr(3'd0, 16'h0000);

    // Coherent COUNT snapshot across a 16-bit boundary
    bus_wr(3'd1, 16'h0001);
    bus_wr(3'd2, 16'h0013);
    bus_wr(3'd0, 16'h0101);
    bus_rd(3'd3, d);
    check("snap LO before cross", 32'(d), 32'h0000);
    bus_rd(3'd4, d);
    check("snap HI after cross", 32'(d), 32'h0013);
    bus_rd(3'd3, d);
    check("snap LO", 32'(d), 32'hFFFF);
    bus_rd(3'd4, d);
    check("snap HI", 32'(d), 32'h0012);
    bus_wr(3'd0, 16'h0000);

    // RELOAD=0 means full 2^24 range
    bus_wr(3'd1, 16'h0000);
    bus_wr(3'd2, 16'h0000);
    bus_wr(3'd0, 16'h0001);
    bus_rd(3'd3, d);
    check("reload0 COUNT_LO", 32'(d), 32'hFFFF);
    bus_rd(3'd4, d);
    check("reload0 COUNT_HI", 32'(d), 32'h00FF);
    bus_wr(3'd0, 16'h0000);

    // Stop write in the expiry cycle suppresses the expiry
    bus_wr(3'd5, 16'h0001);
    bus_wr(3'd1, 16'd5);
    bus_wr(3'd0, 16'h0001);
    t0 = cyc_n;
    while (cyc_n < t0 + 4) cyc();
    bus_wr(3'd0, 16'h0000);
    check("stop-wins tc", 32'(tc), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      seen |= tc;
    end
    check("stop-wins later tc", 32'(seen), 32'd0);
    bus_rd(3'd5, d);
    check("stop-wins STATUS", 32'(d), 32'd0);
    bus_rd(3'd3, d);
    check("stop-wins frozen count", 32'(d), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      cyc();
    end
    sel = 0; we = 0; irq_ack = 0;

    // Asynchronous reset mid-run
    bus_wr(3'd5, 16'h0001);
    bus_wr(3'd1, 16'd3);
    bus_wr(3'd2, 16'd0);
    bus_wr(3'd0, 16'h0005);
    wait_tc(20, t1);
    check("pre-reset irq", 32'(irq), 32'd1);
    #2 reset_n = 0;
    #1;
    model_reset();
    check("async reset outputs", 32'({irq, tc, tp, rvalid}), 32'd0);
    repeat (2) cyc();
    reset_n = 1;
    bus_rd(3'd0, d);
    check("reset CTRL", 32'(d), 32'd0);
    bus_rd(3'd5, d);
    check("reset STATUS", 32'(d), 32'd0);
    bus_rd(3'd3, d);
    check("reset COUNT_LO", 32'(d), 32'd0);
    bus_rd(3'd1, d);
    check("reset RELOAD_LO", 32'(d), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
